// File: rtl/seg_text_scroller_pkg.sv
// Shared definitions for the display controllers: the blank glyph code and the
// scroll sequencer state encoding.
package seg_text_scroller_pkg;

  localparam logic [7:0] ASCII_BLANK = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seg_step_timer.sv
// Prescaler: counts 0..TICKS-1 while enabled and raises o_Tick combinationally
// during the final count; i_Clr forces the count to zero and masks the tick.
module seg_step_timer #(
  parameter int TICKS = 12500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Tick
);

  localparam int CW = $clog2(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] r_Count;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || i_Clr) begin
      r_Count <= '0;
    end else if (i_En) begin
      if (r_Count == LAST) r_Count <= '0;
      else                 r_Count <= r_Count + 1'b1;
    end
  end

  assign o_Tick = i_En & ~i_Clr & (r_Count == LAST);

endmodule

// File: rtl/seg_text_scroller.sv
// Scrolls a buffered message across two 7-segment digits as a two-character
// window over a blank-padded stream; all outputs are registered (1 cycle).
module seg_text_scroller
  import seg_text_scroller_pkg::*;
#(
  parameter int         MSG_DEPTH      = 16,
  parameter int         TICKS_PER_STEP = 12500000,
  parameter logic [7:0] BLANK_CHAR     = ASCII_BLANK
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic                         i_Wr_En,
  input  logic [$clog2(MSG_DEPTH)-1:0] i_Wr_Addr,
  input  logic [7:0]                   i_Wr_Char,
  input  logic [$clog2(MSG_DEPTH):0]   i_Len,
  input  logic                         i_Loop,
  input  logic                         i_Start,
  input  logic                         i_Stop,
  output logic [7:0]                   o_Char_Hi,
  output logic [7:0]                   o_Char_Lo,
  output logic                         o_Busy,
  output logic                         o_Wrap,
  output logic                         o_Done
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(MSG_DEPTH);

  state_e        r_State, w_State_Nxt;
  logic [LW-1:0] r_Win, w_Win_Nxt;
  logic [LW-1:0] r_Len, w_Len_Nxt;
  logic          r_Loop, w_Loop_Nxt;
  logic [7:0]    r_Char_Hi, r_Char_Lo, w_Char_Hi_Nxt, w_Char_Lo_Nxt;
  logic          r_Wrap, r_Done, w_Wrap_Nxt, w_Done_Nxt;
  logic [7:0]    r_Buf [MSG_DEPTH];
  logic          w_Start_Vld, w_Tick, w_Timer_Clr;

  assign w_Start_Vld = i_Start & (i_Len != '0);
  assign w_Timer_Clr = i_Stop | w_Start_Vld | (r_State != RUN);

  seg_step_timer #(.TICKS(TICKS_PER_STEP)) u_step_timer (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Clr   (w_Timer_Clr),
    .i_En    (r_State == RUN),
    .o_Tick  (w_Tick)
  );

  // Stream S[0] and S[L+1] are the blank pads around buf[0..L-1].
  function automatic logic [7:0] stream_at(input logic [LW-1:0] idx,
                                           input logic [LW-1:0] len);
    if (idx != '0 && idx <= len) return r_Buf[AW'(idx - 1'b1)];
    return BLANK_CHAR;
  endfunction

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < MSG_DEPTH; i++) r_Buf[i] <= BLANK_CHAR;
    end else if (i_Wr_En) begin
      r_Buf[i_Wr_Addr] <= i_Wr_Char;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State   <= IDLE;
      r_Win     <= '0;
      r_Len     <= '0;
      r_Loop    <= 1'b0;
      r_Char_Hi <= BLANK_CHAR;
      r_Char_Lo <= BLANK_CHAR;
      r_Wrap    <= 1'b0;
      r_Done    <= 1'b0;
    end else begin
      r_State   <= w_State_Nxt;
      r_Win     <= w_Win_Nxt;
      r_Len     <= w_Len_Nxt;
      r_Loop    <= w_Loop_Nxt;
      r_Char_Hi <= w_Char_Hi_Nxt;
      r_Char_Lo <= w_Char_Lo_Nxt;
      r_Wrap    <= w_Wrap_Nxt;
      r_Done    <= w_Done_Nxt;
    end
  end

  always_comb begin
    w_State_Nxt   = r_State;
    w_Win_Nxt     = r_Win;
    w_Len_Nxt     = r_Len;
    w_Loop_Nxt    = r_Loop;
    w_Wrap_Nxt    = 1'b0;
    w_Done_Nxt    = 1'b0;
    w_Char_Hi_Nxt = BLANK_CHAR;
    w_Char_Lo_Nxt = BLANK_CHAR;

    // Stop beats start, and start beats a coincident step.
    if (i_Stop) begin
      w_State_Nxt = IDLE;
      w_Win_Nxt   = '0;
    end else if (w_Start_Vld) begin
      w_State_Nxt = RUN;
      w_Win_Nxt   = '0;
      w_Len_Nxt   = (i_Len > MAX_LEN) ? MAX_LEN : i_Len;
      w_Loop_Nxt  = i_Loop;
    end else if (r_State == RUN && w_Tick) begin
      if (r_Win < r_Len) begin
        w_Win_Nxt = r_Win + 1'b1;
      end else if (r_Loop) begin
        w_Win_Nxt  = '0;
        w_Wrap_Nxt = 1'b1;
      end else begin
        w_State_Nxt = IDLE;
        w_Win_Nxt   = '0;
        w_Done_Nxt  = 1'b1;
      end
    end

    if (w_State_Nxt == RUN) begin
      w_Char_Hi_Nxt = stream_at(w_Win_Nxt, w_Len_Nxt);
      w_Char_Lo_Nxt = stream_at(w_Win_Nxt + 1'b1, w_Len_Nxt);
    end
  end

  assign o_Char_Hi = r_Char_Hi;
  assign o_Char_Lo = r_Char_Lo;
  assign o_Busy    = (r_State == RUN);
  assign o_Wrap    = r_Wrap;
  assign o_Done    = r_Done;

endmodule

// File: doc/seg_text_scroller.md
Name: seg_text_scroller

Overview:
Sequencer that scrolls a short ASCII message across the board's two 7-segment digits by feeding one character code to each digit's character decoder (i_charselect input).
Holds a small write-port message buffer and a step timer, and emits the current two-character window.
Sits between the top-level/UART command logic and the two decoder instances; the decoders add their own 1-cycle register stage.

Parameters:
MSG_DEPTH, 16, message buffer entries (power of two, 2..64)
TICKS_PER_STEP, 12500000, clock cycles per scroll step (0.5 s at 25 MHz); minimum 2
BLANK_CHAR, 8'h20, code driven on a digit when no message character occupies it

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, synchronous, active-low
i_Wr_En  in  1  write strobe for message buffer
i_Wr_Addr  in  $clog2(MSG_DEPTH)  buffer write address
i_Wr_Char  in  8  ASCII code to write
i_Len  in  $clog2(MSG_DEPTH)+1  message length, sampled on start
i_Loop  in  1  1 = repeat forever, 0 = one pass; sampled on start
i_Start  in  1  start/restart scroll (single-cycle pulse)
i_Stop  in  1  abort scroll (single-cycle pulse)
o_Char_Hi  out  8  code for left digit decoder
o_Char_Lo  out  8  code for right digit decoder
o_Busy  out  1  high while scrolling
o_Wrap  out  1  1-cycle pulse when a looping pass restarts
o_Done  out  1  1-cycle pulse when a one-shot pass completes

Behaviour:
- Clock is i_Clk; reset is synchronous, active-low (i_Rst_L = 0 sampled at a rising edge of i_Clk).
- Reset state: FSM IDLE; o_Char_Hi = o_Char_Lo = BLANK_CHAR; o_Busy, o_Wrap, o_Done = 0; step counter = 0; window index w = 0; all buffer entries = BLANK_CHAR.
- Reset mid-scroll: same as above on the next edge, and the buffer is cleared.
- Buffer writes: when i_Wr_En = 1, write at the edge, in any state. Writes take effect on the next output update. Writes are never blocked.
- Virtual stream for a latched length L: S[0] = BLANK, S[k] = buf[k-1] for 1 <= k <= L, S[L+1] = BLANK.
- Window: o_Char_Hi = S[w], o_Char_Lo = S[w+1]. Outputs are registered and recomputed every cycle while RUN.
- Length latch: on start, L = min(i_Len, MSG_DEPTH). i_Loop is latched at the same edge.
- Start with i_Len = 0 is ignored and the FSM state is unchanged.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on a valid i_Start. Sets w = 0 and counter = 0.
  - The cycle after the start edge: o_Busy = 1, o_Char_Hi = BLANK, o_Char_Lo = buf[0].
  - RUN: counter increments each cycle. When counter = TICKS_PER_STEP-1, set counter = 0 and apply a step.
  - Step with w < L: w = w+1.
  - Step with w = L and loop latched: w = 0, and o_Wrap pulses for 1 cycle.
  - Step with w = L and no loop: go to IDLE. Outputs become BLANK, o_Busy = 0, and o_Done pulses for 1 cycle, all at that same edge.
- First step occurs exactly TICKS_PER_STEP cycles after the start edge. A one-shot pass lasts (L+1)*TICKS_PER_STEP cycles.
- i_Start during RUN restarts the pass: re-latches L and i_Loop, sets w = 0 and counter = 0. No o_Wrap or o_Done pulse.
- i_Stop (RUN or IDLE): go to IDLE, outputs BLANK at the next edge, o_Busy = 0, no o_Done.
- i_Stop and i_Start in the same cycle: i_Stop wins.
- i_Start coincident with a step edge: start wins, and no o_Wrap/o_Done pulse occurs.
- Widths:
  - w is $clog2(MSG_DEPTH)+1 bits.
  - Buffer reads with index >= L return BLANK.
  - Counter is $clog2(TICKS_PER_STEP) bits and never exceeds TICKS_PER_STEP-1.

Decomposition:
- Shared package: ASCII_BLANK (8'h20) and the FSM state enum (IDLE, RUN). Other display controllers import both.
- One sub-module, seg_step_timer: a parameterised prescaler with a clear input and a 1-cycle tick output, reusable by other timing blocks.
- The two decoder instances sit at the top level, not inside this block.

Test Plan:
(all tests use TICKS_PER_STEP = 4, MSG_DEPTH = 16)
- Reset: hold i_Rst_L = 0 for 2 cycles -> outputs 8'h20/8'h20, o_Busy = 0, no pulses. Start with i_Len = 2 and no writes -> every window shows 8'h20.
- One-shot: write "HELLO" to addr 0..4, i_Len = 5, i_Loop = 0, pulse i_Start -> window (Hi,Lo) sequence " H","HE","EL","LL","LO","O " at 4 cycles each. o_Done pulses exactly 24 cycles after the start edge, then o_Busy = 0 and both outputs 8'h20.
- Loop: i_Len = 2 ("AB"), i_Loop = 1 -> windows " A","AB","B ", then " A" repeating. o_Wrap pulses every 12 cycles; o_Done never pulses.
- Stop/priority: assert i_Stop and i_Start in the same cycle during RUN -> IDLE and blank outputs next cycle, no o_Done. Start with i_Len = 0 -> o_Busy stays 0.
- Restart and clamp: i_Start mid-pass -> w = 0 (Hi = 8'h20, Lo = buf[0]) next cycle, and the next step occurs 4 cycles later. i_Len = 20 -> L = 16 and o_Done after 68 cycles.
- Live write: during RUN, write "Z" to the address currently shown on Lo -> o_Char_Lo = "Z" one cycle after the write edge.
